// File: rtl/uart_pkg.sv
// Shared types and constants for the round-robin UART transmit scheduler.
// State list includes PARITY; it is only entered when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int   UART_DATA_W   = 8;
  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_rr_scheduler_if.sv
// Requester, baud-generator and serial-line signals of the TX scheduler.
// master = requesters/generator side, slave = scheduler side.
interface uart_tx_rr_scheduler_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]             req;
  logic [UART_DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             ack;
  logic [2:0]                     gnt_id;
  logic                           busy;
  logic                           baud_en;
  logic                           baud_tick;
  logic                           txd;

  modport master (
    output req, req_data, baud_tick,
    input  ack, gnt_id, busy, baud_en, txd
  );

  modport slave (
    input  req, req_data, baud_tick,
    output ack, gnt_id, busy, baud_en, txd
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant over NUM_REQ level requests; searches upward from ptr with
// wrap, and moves ptr just past the winner when the owner strobes advance.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic               gnt_vld,
  output logic [2:0]         gnt_idx,
  output logic [NUM_REQ-1:0] gnt_oh
);

  logic [2:0]         ptr;
  logic [NUM_REQ-1:0] rot;
  logic [3:0]         slot;

  // Rotate so that rot[0] is the requester at ptr; lowest set bit wins.
  always_comb begin
    rot     = NUM_REQ'({req, req} >> ptr);
    gnt_vld = 1'b0;
    gnt_idx = '0;
    slot    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_vld = 1'b1;
        slot    = {1'b0, ptr} + 4'(k);
        if (slot >= 4'(NUM_REQ)) slot = slot - 4'(NUM_REQ);
        gnt_idx = slot[2:0];
      end
    end
    gnt_oh = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && gnt_vld) begin
      ptr <= (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
    end
  end

endmodule

// File: rtl/uart_tx_rr_scheduler.sv
// Shares one UART TX line among NUM_REQ byte requesters with round-robin arbitration.
// Frame: start, 8 data bits LSB-first, optional even parity (UART_TX_PARITY_EN), STOP_BITS stops.
module uart_tx_rr_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int STOP_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_rr_scheduler_if.slave bus
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  uart_tx_state_t         state, state_n;
  logic [UART_DATA_W-1:0] shift_q, shift_n, sel_byte;
  logic [2:0]             bit_cnt, bit_cnt_n;
  logic                   stop_cnt, stop_cnt_n;
  logic                   txd_q, txd_n;
  logic                   busy_q, busy_n;
  logic                   baud_en_q, baud_en_n;
  logic [NUM_REQ-1:0]     ack_q, ack_n;
  logic [2:0]             gnt_q, gnt_n;
  logic                   tick;
  logic                   advance;
  logic                   gnt_vld;
  logic [2:0]             gnt_idx;
  logic [NUM_REQ-1:0]     gnt_oh;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_n;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req),
    .advance (advance),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .gnt_oh  (gnt_oh)
  );

  // The generator is idle while baud_en is low, so its tick is masked there.
  assign tick = bus.baud_tick & baud_en_q;

  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_oh[k]) sel_byte = sel_byte | bus.req_data[k*UART_DATA_W +: UART_DATA_W];
    end
  end

  always_comb begin
    state_n    = state;
    shift_n    = shift_q;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    txd_n      = txd_q;
    busy_n     = busy_q;
    baud_en_n  = baud_en_q;
    ack_n      = '0;
    gnt_n      = gnt_q;
    advance    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n      = par_q;
`endif
    unique case (state)
      ST_IDLE: begin
        if (gnt_vld) begin
          advance   = 1'b1;
          ack_n     = gnt_oh;
          gnt_n     = gnt_idx;
          shift_n   = sel_byte;
          busy_n    = 1'b1;
          baud_en_n = 1'b1;
          txd_n     = ~UART_IDLE_LVL;
          state_n   = ST_START;
`ifdef UART_TX_PARITY_EN
          par_n     = ^sel_byte;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          txd_n     = shift_q[0];
          shift_n   = shift_q >> 1;
          bit_cnt_n = '0;
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_n      = par_q;
            state_n    = ST_PARITY;
`else
            txd_n      = UART_IDLE_LVL;
            stop_cnt_n = 1'b0;
            state_n    = ST_STOP;
`endif
          end else begin
            txd_n     = shift_q[0];
            shift_n   = shift_q >> 1;
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          txd_n      = UART_IDLE_LVL;
          stop_cnt_n = 1'b0;
          state_n    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            busy_n    = 1'b0;
            baud_en_n = 1'b0;
            state_n   = ST_IDLE;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Control registers: reset drives the line idle at once, truncating any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      txd_q     <= UART_IDLE_LVL;
      busy_q    <= 1'b0;
      baud_en_q <= 1'b0;
      ack_q     <= '0;
      gnt_q     <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      stop_cnt  <= stop_cnt_n;
      txd_q     <= txd_n;
      busy_q    <= busy_n;
      baud_en_q <= baud_en_n;
      ack_q     <= ack_n;
      gnt_q     <= gnt_n;
    end
  end

  // Data registers: only meaningful after a grant loads them.
  always_ff @(posedge clk) begin
    shift_q <= shift_n;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_n;
`endif
  end

  assign bus.txd     = txd_q;
  assign bus.busy    = busy_q;
  assign bus.baud_en = baud_en_q;
  assign bus.ack     = ack_q;
  assign bus.gnt_id  = gnt_q;

endmodule

// File: tb/tb_uart_tx_rr_scheduler.sv
// Bench for uart_tx_rr_scheduler: baud generator model, round-robin reference model,
// frame capture at mid-bit. Honours UART_TX_PARITY_EN for frame length and content.
module tb_uart_tx_rr_scheduler;
  import uart_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int STOP_BITS = 2;
  localparam int P         = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 1 + 8 + 1 + STOP_BITS;
`else
  localparam int NB = 1 + 8 + STOP_BITS;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_tick = 1'b0;
  int   bcnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   ptr_m = 0;
  int   last_gnt = 0;

  always #5 clk = ~clk;

  uart_tx_rr_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_rr_scheduler #(.NUM_REQ(NUM_REQ), .STOP_BITS(STOP_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Baud generator: held in reload while disabled, tick every P clocks when enabled.
  always @(posedge clk) begin
    if (!bus.baud_en) bcnt <= 0;
    else if (bcnt == P - 1) bcnt <= 0;
    else bcnt <= bcnt + 1;
  end
  assign bus.baud_tick = (bus.baud_en && bcnt == P - 1) || force_tick;

  // Reference arbitration: first set request at or above the pointer, wrapping.
  function automatic int model_grant(input logic [NUM_REQ-1:0] m);
    int mi = int'(m);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx = (ptr_m + k) % NUM_REQ;
      if (((mi >> idx) & 1) != 0) begin
        ptr_m    = (idx + 1) % NUM_REQ;
        last_gnt = idx;
        return idx;
      end
    end
    return -1;
  endfunction

  // Expected line levels, bit 0 = first bit on the wire.
  function automatic logic [NB-1:0] exp_frame(input int b);
    int v, p;
    p = 0;
    for (int k = 0; k < 8; k++) p = p ^ ((b >> k) & 1);
`ifdef UART_TX_PARITY_EN
    v = ((b & 255) << 1) | (p << 9) | (((1 << STOP_BITS) - 1) << 10);
`else
    v = ((b & 255) << 1) | (((1 << STOP_BITS) - 1) << 9);
`endif
    return NB'(v);
  endfunction

  // Waits (bounded) for a grant, then records the frame at mid-bit plus busy/ack behaviour.
  task automatic wait_frame(input logic auto_drop, output logic ok, output int gap,
                            output logic txd0, output logic [NUM_REQ-1:0] ack_o,
                            output logic [NUM_REQ-1:0] ack_nx, output logic [2:0] gid_o,
                            output logic [NB-1:0] bits_o, output int busy_lo,
                            output logic busy_end);
    ok = 1'b0; gap = 0; txd0 = 1'b1; ack_o = '0; ack_nx = '0; gid_o = '0;
    bits_o = '0; busy_lo = 0; busy_end = 1'b1;
    while (gap < 400) begin
      @(negedge clk);
      gap++;
      if (bus.ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    ack_o = bus.ack;
    gid_o = bus.gnt_id;
    txd0  = bus.txd;
    if (auto_drop) bus.req = bus.req & ~bus.ack;
    for (int n = 0; n < NB * P; n++) begin
      if (n != 0) @(negedge clk);
      if (n == 1) ack_nx = bus.ack;
      if (bus.busy !== 1'b1) busy_lo++;
      if (n % P == P / 2) bits_o = {bus.txd, bits_o[NB-1:1]};
    end
    @(negedge clk);
    busy_end = bus.busy;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_data = '0; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ptr_m = 0; last_gnt = 0;
    n_checks++; if (bus.txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", bus.txd); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.baud_en !== 1'b0) begin n_fail++; $display("FAIL reset_baud_en: got %b want 0", bus.baud_en); end
    n_checks++; if (bus.ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", bus.ack); end
    n_checks++; if (bus.gnt_id !== 3'd0) begin n_fail++; $display("FAIL reset_gnt_id: got %0d want 0", bus.gnt_id); end
  endtask

  task automatic test_round_robin();
    logic ok, txd0, busy_end; int gap, busy_lo, eid;
    logic [NUM_REQ-1:0] ack_o, ack_nx; logic [2:0] gid; logic [NB-1:0] bits;
    bus.req_data = 32'h13121110;
    bus.req = 4'hF;
    for (int f = 0; f < 5; f++) begin
      wait_frame(1'b0, ok, gap, txd0, ack_o, ack_nx, gid, bits, busy_lo, busy_end);
      eid = model_grant(4'hF);
      n_checks++; if (!ok || gap != 1) begin n_fail++; $display("FAIL rr_gap f%0d: ok=%b gap=%0d want ok=1 gap=1", f, ok, gap); end
      n_checks++; if (gid !== 3'(eid)) begin n_fail++; $display("FAIL rr_gnt_id f%0d: got %0d want %0d", f, gid, eid); end
      n_checks++; if (ack_o !== 4'(1 << eid) || ack_nx !== 4'b0) begin n_fail++; $display("FAIL rr_ack f%0d: got %b then %b want %b then 0000", f, ack_o, ack_nx, 4'(1 << eid)); end
      n_checks++; if (bits !== exp_frame(16 + eid)) begin n_fail++; $display("FAIL rr_bits f%0d: got %b want %b", f, bits, exp_frame(16 + eid)); end
      n_checks++; if (busy_lo != 0 || busy_end !== 1'b0) begin n_fail++; $display("FAIL rr_busy f%0d: low_cycles=%0d end=%b want 0/0", f, busy_lo, busy_end); end
    end
    bus.req = '0;
  endtask

  task automatic test_single();
    logic ok, txd0, busy_end; int gap, busy_lo, eid;
    logic [NUM_REQ-1:0] ack_o, ack_nx; logic [2:0] gid; logic [NB-1:0] bits;
    bus.req_data = $urandom();
    bus.req_data[23:16] = 8'hA5;
    bus.req = 4'b0100;
    wait_frame(1'b1, ok, gap, txd0, ack_o, ack_nx, gid, bits, busy_lo, busy_end);
    eid = model_grant(4'b0100);
    n_checks++; if (!ok || gap != 1 || txd0 !== 1'b0) begin n_fail++; $display("FAIL single_latency: ok=%b gap=%0d txd=%b want 1/1/0", ok, gap, txd0); end
    n_checks++; if (ack_o !== 4'b0100 || ack_nx !== 4'b0) begin n_fail++; $display("FAIL single_ack: got %b then %b want 0100 then 0000", ack_o, ack_nx); end
    n_checks++; if (gid !== 3'(eid)) begin n_fail++; $display("FAIL single_gnt_id: got %0d want %0d", gid, eid); end
    n_checks++; if (bits !== exp_frame(32'hA5)) begin n_fail++; $display("FAIL single_bits: got %b want %b", bits, exp_frame(32'hA5)); end
    n_checks++; if (busy_lo != 0 || busy_end !== 1'b0) begin n_fail++; $display("FAIL single_busy: low_cycles=%0d end=%b want 0/0", busy_lo, busy_end); end
  endtask

  task automatic test_ptr_wrap();
    logic ok, txd0, busy_end; int gap, busy_lo, eid;
    logic [NUM_REQ-1:0] ack_o, ack_nx; logic [2:0] gid; logic [NB-1:0] bits;
    logic [31:0] d;
    d = $urandom();
    bus.req_data = d;
    bus.req = 4'b0101;
    for (int f = 0; f < 2; f++) begin
      wait_frame(1'b1, ok, gap, txd0, ack_o, ack_nx, gid, bits, busy_lo, busy_end);
      eid = model_grant(f == 0 ? 4'b0101 : 4'b0100);
      n_checks++; if (!ok || gap != 1 || gid !== 3'(eid)) begin n_fail++; $display("FAIL wrap_gnt f%0d: ok=%b gap=%0d gnt=%0d want gnt %0d", f, ok, gap, gid, eid); end
      n_checks++; if (bits !== exp_frame(int'((d >> (8 * eid)) & 32'hFF))) begin n_fail++; $display("FAIL wrap_bits f%0d: got %b want %b", f, bits, exp_frame(int'((d >> (8 * eid)) & 32'hFF))); end
    end
    bus.req = '0;
  endtask

  task automatic test_idle_ticks();
    int bad = 0;
    bus.req = '0;
    for (int c = 0; c < 40; c++) begin
      force_tick = (c % 4 == 1);
      @(negedge clk);
      if (bus.txd !== 1'b1 || bus.baud_en !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 4'b0) bad++;
    end
    force_tick = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_ticks: %0d disturbed cycles want 0", bad); end
    n_checks++; if (bus.gnt_id !== 3'(last_gnt)) begin n_fail++; $display("FAIL idle_gnt_hold: got %0d want %0d", bus.gnt_id, last_gnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic ok, txd0, busy_end; int gap, busy_lo, eid, t;
    logic [NUM_REQ-1:0] ack_o, ack_nx; logic [2:0] gid; logic [NB-1:0] bits;
    logic [31:0] d;
    bus.req_data = $urandom();
    bus.req = 4'b0001;
    t = 0;
    while (bus.ack == 4'b0 && t < 100) begin @(negedge clk); t++; end
    n_checks++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL rstmid_ack: got %b want 0001", bus.ack); end
    eid = model_grant(4'b0001);
    bus.req = '0;
    repeat (4 * P + P / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.txd !== 1'b1 || bus.busy !== 1'b0 || bus.baud_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: txd=%b busy=%b baud_en=%b want 1/0/0", bus.txd, bus.busy, bus.baud_en); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr_m = 0; last_gnt = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.ack !== 4'b0 || bus.txd !== 1'b1) begin n_fail++; $display("FAIL rstmid_quiet: ack=%b txd=%b want 0000/1", bus.ack, bus.txd); end
    d = $urandom();
    bus.req_data = d;
    bus.req = 4'b0010;
    wait_frame(1'b1, ok, gap, txd0, ack_o, ack_nx, gid, bits, busy_lo, busy_end);
    eid = model_grant(4'b0010);
    n_checks++; if (!ok || gid !== 3'(eid) || ack_o !== 4'(1 << eid)) begin n_fail++; $display("FAIL rstmid_regrant: ok=%b gnt=%0d ack=%b want gnt %0d", ok, gid, ack_o, eid); end
    n_checks++; if (bits !== exp_frame(int'((d >> 8) & 32'hFF))) begin n_fail++; $display("FAIL rstmid_bits: got %b want %b", bits, exp_frame(int'((d >> 8) & 32'hFF))); end
  endtask

  task automatic test_random();
    logic ok, txd0, busy_end; int gap, busy_lo, eid;
    logic [NUM_REQ-1:0] ack_o, ack_nx, m; logic [2:0] gid; logic [NB-1:0] bits;
    logic [31:0] d;
    for (int it = 0; it < 10; it++) begin
      m = 4'($urandom_range(1, 15));
      d = $urandom();
      bus.req_data = d;
      bus.req = m;
      wait_frame(1'b1, ok, gap, txd0, ack_o, ack_nx, gid, bits, busy_lo, busy_end);
      bus.req = '0;
      eid = model_grant(m);
      n_checks++; if (!ok || gid !== 3'(eid) || ack_o !== 4'(1 << eid)) begin n_fail++; $display("FAIL rand_gnt i%0d: req=%b ok=%b gnt=%0d ack=%b want gnt %0d", it, m, ok, gid, ack_o, eid); end
      n_checks++; if (bits !== exp_frame(int'((d >> (8 * eid)) & 32'hFF)) || busy_lo != 0) begin n_fail++; $display("FAIL rand_frame i%0d: got %b busy_low=%0d want %b", it, bits, busy_lo, exp_frame(int'((d >> (8 * eid)) & 32'hFF))); end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic ok, txd0, busy_end; int gap, busy_lo, eid;
    logic [NUM_REQ-1:0] ack_o, ack_nx; logic [2:0] gid; logic [NB-1:0] bits;
    logic [7:0] b;
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 8'h07 : 8'h03;
      bus.req_data = {4{b}};
      bus.req = 4'hF;
      wait_frame(1'b1, ok, gap, txd0, ack_o, ack_nx, gid, bits, busy_lo, busy_end);
      bus.req = '0;
      eid = model_grant(4'hF);
      n_checks++; if (!ok || bits[9] !== (f == 0)) begin n_fail++; $display("FAIL parity_bit %h: got %b want %b", b, bits[9], (f == 0)); end
      n_checks++; if (bits !== exp_frame(int'(b)) || busy_lo != 0 || busy_end !== 1'b0) begin n_fail++; $display("FAIL parity_frame %h: got %b busy_low=%0d end=%b want %b", b, bits, busy_lo, busy_end, exp_frame(int'(b))); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_ptr_wrap();
    test_idle_ticks();
    test_reset_mid_frame();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_rr_scheduler.md
Name: uart_tx_rr_scheduler

Overview:
Shares one 8-bit serial TX line among NUM_REQ byte requesters (GPS config, debug, telemetry) using round-robin arbitration. Latches the granted byte and frames it as start, 8 data bits LSB-first and STOP_BITS stop bits. Pacing comes from the existing baud tick generator: this block drives that generator's enable and consumes its tick.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
STOP_BITS, 2, stop bits per frame (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req  in  NUM_REQ  per-requester level request; held until ack
req_data  in  8*NUM_REQ  flattened bytes; requester i at [8i+7:8i]
ack  out  NUM_REQ  one-hot, 1-cycle pulse when requester's byte is latched
gnt_id  out  3  index of the requester owning the current frame
busy  out  1  high from latch cycle until last stop bit ends
baud_en  out  1  enable to the baud tick generator
baud_tick  in  1  1-cycle tick per bit period from the generator
txd  out  1  serial output, idle high

Behaviour:
- Reset values: txd=1, busy=0, baud_en=0, ack=0, gnt_id=0, RR pointer=0, state=IDLE.
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE: if any req bit is set, grant the first set bit searching from ptr upward, wrapping modulo NUM_REQ. Same cycle: pulse ack[i], latch req_data[i] into an 8-bit shift register, set gnt_id=i, set ptr=(i+1) mod NUM_REQ, busy=1, baud_en=1, txd=0, go to START. Latency from req to txd low is 1 clk.
- The generator reloads while disabled, so the first baud_tick arrives one bit period after baud_en rises. Each baud_tick ends the current bit.
- START: on tick, txd=shift[0], bit counter=0, go to DATA.
- DATA: on tick, shift right; after bit 7 ends go to STOP (or PARITY); txd=1.
- STOP: count STOP_BITS ticks with txd=1. On the final tick:
  - busy=0 and baud_en=0 in the same cycle; go to IDLE.
  - The next frame may start on the following clk, giving back-to-back frames with no extra idle bit.
- Ticks seen in IDLE are ignored. baud_tick is never sampled when baud_en=0.
- req dropped mid-frame: no effect; the byte is already latched.
- req[i] still high after ack: treated as a new request, subject to round-robin.
- No requests: remain in IDLE with baud_en=0.
- Fairness: with all requesters continuously asserting, grants go 0,1,2,3,0,…
- Async reset mid-frame: txd goes to 1 immediately; the frame is truncated; no ack is reissued.
- gnt_id keeps its value after a frame until the next grant.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA. It transmits the even-parity bit (XOR of the latched byte) for one tick before STOP.
- Undefined: no parity state; frame is 8N{STOP_BITS}.
- Arbitration and handshake are identical either way.

Decomposition:
- Shared package `uart_pkg`:
  - state encoding typedef `uart_tx_state_t`
  - constant `UART_DATA_W=8`
  - constant `UART_IDLE_LVL=1'b1`
- Sub-module `rr_arbiter`: combinational-plus-pointer round-robin grant for NUM_REQ. Owns the ptr register and updates it on an advance strobe.
- Framing FSM and shift register live in the top module.

Test Plan:
- Single byte: req[2]=1, byte 0xA5, ticks every 16 clk, STOP_BITS=2.
  - ack[2] pulses in 1 clk; gnt_id=2.
  - txd sequence: 0,1,0,1,0,0,1,0,1,1,1.
  - busy is high for exactly 11 tick periods.
- Round-robin: req=4'b1111 held, bytes 0x10/0x11/0x12/0x13, then held again.
  - Frames go out in order 0,1,2,3,0.
  - Each ack is a single pulse; frames are back-to-back with no gap clock.
- Pointer wrap: ptr=3 after granting 2, req=4'b0101 → grant 0 next, then 2.
- Reset mid-frame: assert rst during DATA bit 3.
  - txd=1, busy=0, baud_en=0 asynchronously.
  - After release, a new req[1] frame is correct.
- Idle ticks: pulse baud_tick with no req → no txd change, baud_en stays 0.
- UART_TX_PARITY_EN: byte 0x07 → parity bit 1 before stops. Byte 0x03 → parity bit 0. Frame is 12 tick periods.
